// File: rtl/mem_wr_packer_if.sv
// Write-stream bundle between a word producer and the block-write packer.
// Latency: none (wires only).
// Backpressure: producer holds i_data/i_last while o_ready is low.
//
// Ports (slave = packer side):
//   i_start, i_base_addr          stream start pulse and first word address
//   i_data, i_valid, i_last       word stream (valid/ready handshake)
//   o_ready                       packer accepts a word this cycle
//   o_addr_w, o_data_w, o_wr_size block write toward the memory
//   o_wr_en, o_busy, o_done       write strobe and stream status
interface mem_wr_packer_if #(
    parameter int SIZE       = 32,
    parameter int BLOCK_SIZE = 5,
    parameter int ADDR_SIZE  = 24
);
    logic                          i_start;
    logic [ADDR_SIZE-1:0]          i_base_addr;
    logic [SIZE-1:0]               i_data;
    logic                          i_valid;
    logic                          i_last;
    logic                          o_ready;
    logic [ADDR_SIZE-1:0]          o_addr_w;
    logic [SIZE*BLOCK_SIZE-1:0]    o_data_w;
    logic [$clog2(BLOCK_SIZE)-1:0] o_wr_size;
    logic                          o_wr_en;
    logic                          o_busy;
    logic                          o_done;

    modport slave (
        input  i_start, i_base_addr, i_data, i_valid, i_last,
        output o_ready, o_addr_w, o_data_w, o_wr_size, o_wr_en, o_busy, o_done
    );

    modport master (
        output i_start, i_base_addr, i_data, i_valid, i_last,
        input  o_ready, o_addr_w, o_data_w, o_wr_size, o_wr_en, o_busy, o_done
    );
endinterface

// File: rtl/mem_wr_packer.sv
// Packs a word stream into block writes of up to BLOCK_SIZE words (word 0 in MSBs).
// Latency: block write registered, presented the cycle after its completing word.
// Backpressure: none inside a stream (o_ready=1 throughout FILL); idle/done cycles stall.
//
// Ports:
//   i_clk  clock, all state on rising edge
//   i_rst  asynchronous active-high reset, drops any partial block
//   bus    mem_wr_packer_if.slave: stream in, block write out, busy/done status
module mem_wr_packer #(
    parameter int SIZE       = 32,
    parameter int BLOCK_SIZE = 5,
    parameter int ADDR_SIZE  = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mem_wr_packer_if.slave    bus
);
    localparam int CW = $clog2(BLOCK_SIZE);
    localparam int DW = SIZE * BLOCK_SIZE;
    localparam logic [CW-1:0] LAST_SLOT = CW'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                               state_q, state_d;
    logic [CW-1:0]                        count_q, count_d;
    logic [BLOCK_SIZE-1:0][SIZE-1:0]      buf_q, buf_d;
    logic [ADDR_SIZE-1:0]                 next_addr_q, next_addr_d;
    logic [ADDR_SIZE-1:0]                 addr_w_q, addr_w_d;
    logic [DW-1:0]                        data_w_q, data_w_d;
    logic [CW-1:0]                        wr_size_q, wr_size_d;
    logic                                 wr_en_q, wr_en_d;

    // Fill buffer with the incoming word dropped into slot count_q. Slots
    // beyond count_q are always zero because the buffer is cleared on every
    // emit and on start, so this is directly the block image to write.
    logic [BLOCK_SIZE-1:0][SIZE-1:0]      buf_ins;
    logic [DW-1:0]                        blk_data;
    logic [CW-1:0]                        blk_size;
    logic                                 accept;

    always_comb begin
        buf_ins  = buf_q;
        blk_data = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (i == int'(count_q)) begin
                buf_ins[i] = bus.i_data;
            end
            blk_data[(BLOCK_SIZE-i)*SIZE-1 -: SIZE] = buf_ins[i];
        end
    end

    assign blk_size = count_q + CW'(1);
    assign accept   = (state_q == FILL) && bus.i_valid;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        buf_d       = buf_q;
        next_addr_d = next_addr_q;
        addr_w_d    = '0;
        data_w_d    = '0;
        wr_size_d   = '0;
        wr_en_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    next_addr_d = bus.i_base_addr;
                    count_d     = '0;
                    buf_d       = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    if ((count_q == LAST_SLOT) || bus.i_last) begin
                        // Emit the block; a last word on a full block yields
                        // exactly one full write, never an empty trailer.
                        addr_w_d    = next_addr_q;
                        data_w_d    = blk_data;
                        wr_size_d   = blk_size;
                        wr_en_d     = 1'b1;
                        next_addr_d = next_addr_q + ADDR_SIZE'(blk_size);
                        count_d     = '0;
                        buf_d       = '0;
                        if (bus.i_last) begin
                            state_d = DONE;
                        end
                    end else begin
                        buf_d   = buf_ins;
                        count_d = blk_size;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            buf_q       <= '0;
            next_addr_q <= '0;
            addr_w_q    <= '0;
            data_w_q    <= '0;
            wr_size_q   <= '0;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            buf_q       <= buf_d;
            next_addr_q <= next_addr_d;
            addr_w_q    <= addr_w_d;
            data_w_q    <= data_w_d;
            wr_size_q   <= wr_size_d;
            wr_en_q     <= wr_en_d;
        end
    end

    assign bus.o_ready   = (state_q == FILL);
    assign bus.o_busy    = (state_q != IDLE);
    // The final write is always the one presented while in DONE.
    assign bus.o_done    = (state_q == DONE);
    assign bus.o_wr_en   = wr_en_q;
    assign bus.o_addr_w  = addr_w_q;
    assign bus.o_data_w  = data_w_q;
    assign bus.o_wr_size = wr_size_q;
endmodule

// File: tb/tb_mem_wr_packer.sv
module tb_mem_wr_packer;
    localparam int SIZE = 32;
    localparam int BS   = 5;
    localparam int AW   = 24;
    localparam int CW   = $clog2(BS);
    localparam int DW   = SIZE * BS;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] size;
        logic          done;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_wr_packer_if #(.SIZE(SIZE), .BLOCK_SIZE(BS), .ADDR_SIZE(AW)) bus ();

    mem_wr_packer #(.SIZE(SIZE), .BLOCK_SIZE(BS), .ADDR_SIZE(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    exp_t          sb[$];
    logic [31:0]   words[$];
    exp_t          mon_e;
    int            cyc    = 0;
    int            n_chk  = 0;
    int            n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: block b of an n-word stream starting at base.
    function automatic exp_t model_block(input logic [AW-1:0] base, input int n, input int b);
        exp_t e;
        int   sz;
        sz     = (n - BS*b > BS) ? BS : n - BS*b;
        e.addr = base + AW'(BS*b);
        e.size = CW'(sz);
        e.data = '0;
        for (int s = 0; s < sz; s++) begin
            e.data[(BS-s)*SIZE-1 -: SIZE] = words[BS*b+s];
        end
        e.done = (BS*b + sz == n);
        e.cyc  = 0;
        return e;
    endfunction

    task automatic fill_words(input int n);
        words.delete();
        repeat (n) words.push_back($urandom);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, bus.o_ready, 0);
        chk({nm, "_wr_en"}, bus.o_wr_en, 0);
        chk({nm, "_done"},  bus.o_done, 0);
        chk({nm, "_busy"},  bus.o_busy, 0);
        chk({nm, "_addr"},  bus.o_addr_w, 0);
        chk({nm, "_size"},  bus.o_wr_size, 0);
        chk({nm, "_data"},  bus.o_data_w, 0);
    endtask

    // Entered and left at posedge+#1 with the DUT in IDLE.
    task automatic run_stream(input logic [AW-1:0] base, input int n, input int gap_max,
                              input int ign_idx, input int rst_after);
        exp_t e;
        int   ngap;
        chk("idle_ready", bus.o_ready, 0);
        bus.i_start     = 1'b1;
        bus.i_base_addr = base;
        @(posedge clk); #1;
        bus.i_start     = 1'b0;
        bus.i_base_addr = AW'($urandom);
        chk("start_ready", bus.o_ready, 1);
        chk("start_busy", bus.o_busy, 1);
        for (int j = 0; j < n; j++) begin
            ngap = (gap_max > 0) ? $urandom_range((j == 0) ? 1 : 0, gap_max) : 0;
            repeat (ngap) begin
                bus.i_valid = 1'b0;
                bus.i_data  = $urandom;
                bus.i_last  = 1'($urandom);
                @(posedge clk); #1;
                chk("gap_ready", bus.o_ready, 1);
            end
            bus.i_data  = words[j];
            bus.i_valid = 1'b1;
            bus.i_last  = (j == n - 1);
            if (j == ign_idx) begin
                bus.i_start     = 1'b1;
                bus.i_base_addr = 24'h000999;
            end
            chk("fill_ready", bus.o_ready, 1);
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            bus.i_last  = 1'b0;
            bus.i_start = 1'b0;
            if ((j % BS == BS - 1) || (j == n - 1)) begin
                e     = model_block(base, n, j / BS);
                e.cyc = cyc;
                sb.push_back(e);
            end
            if (j + 1 == rst_after) begin
                rst = 1'b1;
                #1;
                chk_all_zero("midrst");
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
        end
        chk("done_ready", bus.o_ready, 0);
        chk("done_busy", bus.o_busy, 1);
        @(posedge clk); #1;
        chk("post_ready", bus.o_ready, 0);
        chk("post_busy", bus.o_busy, 0);
    endtask

    // Monitor: every write must match the next expected block, in the expected cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_wr_en) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got write addr %0h size %0d, expected none",
                             bus.o_addr_w, bus.o_wr_size);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_addr", bus.o_addr_w, mon_e.addr);
                    chk("wr_size", bus.o_wr_size, mon_e.size);
                    chk("wr_data", bus.o_data_w, mon_e.data);
                    chk("wr_done", bus.o_done, mon_e.done);
                    chk("wr_cycle", cyc, mon_e.cyc);
                end
            end else begin
                chk("idle_done", bus.o_done, 0);
                chk("idle_addr_size", {bus.o_addr_w, bus.o_wr_size}, 0);
                chk("idle_data", bus.o_data_w, 0);
            end
        end
    end

    initial begin
        int n;
        bus.i_start     = 1'b0;
        bus.i_base_addr = '0;
        bus.i_data      = '0;
        bus.i_valid     = 1'b0;
        bus.i_last      = 1'b0;
        rst             = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        fill_words(5);  run_stream(24'h000100, 5, 0, -1, -1);
        fill_words(12); run_stream(24'h000100, 12, 0, -1, -1);
        fill_words(1);  words[0] = 32'hDEADBEEF;
        run_stream(24'h000200, 1, 4, -1, -1);
        fill_words(7);  run_stream(24'hFFFFFE, 7, 0, -1, -1);
        fill_words(5);  run_stream(24'h000040, 5, 0, -1, 3);
        fill_words(5);  run_stream(24'h000020, 5, 0, -1, -1);
        fill_words(13); run_stream(24'h000100, 13, 1, 7, -1);

        repeat (8) begin
            n = $urandom_range(1, 17);
            fill_words(n);
            run_stream(AW'($urandom), n, 2, $urandom_range(0, n - 1), -1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
